// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver, 8 data bits LSB first, 1 stop bit.
// Optional even parity (8E1) is compiled in when UART_RX_PARITY_EN is defined;
// otherwise the frame is 8N1 and parity_err is tied low.
// Reset is synchronous, active-low, on input rst.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    // Clocks per oversampling tick; truncated on purpose.
    localparam int DIV = CLK_FREQ / (16 * BAUD_RATE);
    localparam int DW  = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $error("uart_rx: CLK_FREQ/(16*BAUD_RATE) must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_s_q, rx_s_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    tcnt_q, tcnt_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_done_q, rx_done_d;
    logic          frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic          par_bit_q, par_bit_d;
    logic          parity_err_q, parity_err_d;
`endif
    logic          tick;

    assign tick = (div_q == DW'(DIV - 1));

    // Next-state logic: synchronizer, tick divider, and the receive FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        div_d       = tick ? '0 : div_q + DW'(1);
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    // Realign the tick phase to the start edge.
                    state_d = S_START;
                    tcnt_d  = 4'd0;
                    div_d   = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tcnt_q == 4'd7) begin
                        if (rx_s_q) begin
                            state_d = S_IDLE;      // glitch, not a start bit
                        end else begin
                            tcnt_d  = 4'd0;
                            bcnt_d  = 3'd0;
                            state_d = S_DATA;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;        // wraps 15 -> 0 at each sample
                    if (tcnt_q == 4'd15) begin
                        shift_d[bcnt_q] = rx_s_q;
                        bcnt_d          = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        par_bit_d = rx_s_q;
                        state_d   = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        if (!rx_s_q) begin
                            // Frame error takes priority over a parity error.
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
`ifdef UART_RX_PARITY_EN
                        end else if ((^shift_q) ^ par_bit_q) begin
                            parity_err_d = 1'b1;
                            state_d      = S_IDLE;
`endif
                        end else begin
                            rx_data_d = shift_q;
                            rx_done_d = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger.
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            div_q       <= '0;
            state_q     <= S_IDLE;
            tcnt_q      <= 4'd0;
            bcnt_q      <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            div_q       <= div_d;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at DIV=10 (160 clocks per bit).
module tb_uart_rx;

    localparam int BIT = 160;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 1683;   // start edge to rx_done, 10.5 bit-times + pipeline
`else
    localparam int LAT = 1523;   // start edge to rx_done, 9.5 bit-times + pipeline
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, consec = 0;
    int done_cyc = 0;
    logic prev_done = 1'b0;
    logic [7:0] got_q[$];

    int d0, f0, p0, t0;

    uart_rx #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_done(rx_done),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            got_q.push_back(rx_data);
            if (prev_done) consec = consec + 1;
        end
        if (frame_err)  ferr_cnt = ferr_cnt + 1;
        if (parity_err) perr_cnt = perr_cnt + 1;
        prev_done = rx_done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_v);
    endtask

    task automatic snap();
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    endtask

    initial begin
        // Reset
        rst = 1'b0; rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_done", rx_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        idle(20);

        // Good frame 0x81 with latency window
        snap();
        t0 = cyc;
        send_frame(8'h81, 1'b1);
        idle(100);
        check("good_done_cnt", done_cnt - d0, 1);
        check("good_data", rx_data, 8'h81);
        check("good_latency", ((done_cyc - t0) >= LAT - 6) && ((done_cyc - t0) <= LAT + 6), 1'b1);
        check("good_no_ferr", ferr_cnt - f0, 0);
        check("good_no_perr", perr_cnt - p0, 0);
        check("good_idle_busy", busy, 1'b0);

        // Back-to-back frames
        snap();
        got_q.delete();
        send_frame(8'h80, 1'b1);
        send_frame(8'h83, 1'b1);
        send_frame(8'h84, 1'b1);
        idle(100);
        check("b2b_done_cnt", done_cnt - d0, 3);
        check("b2b_q_size", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("b2b_byte0", got_q[0], 8'h80);
            check("b2b_byte1", got_q[1], 8'h83);
            check("b2b_byte2", got_q[2], 8'h84);
        end
        check("b2b_no_ferr", ferr_cnt - f0, 0);

        // Glitch rejection
        snap();
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_busy_mid", busy, 1'b1);
        idle(200);
        check("glitch_busy_end", busy, 1'b0);
        check("glitch_no_done", done_cnt - d0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_no_perr", perr_cnt - p0, 0);
        check("glitch_data", rx_data, 8'h84);

        // Frame error, line held low afterwards
        snap();
        send_frame(8'h82, 1'b0);
        rx = 1'b0;
        repeat (500) @(negedge clk);
        check("ferr_break_busy", busy, 1'b1);
        idle(200);
        check("ferr_cnt", ferr_cnt - f0, 1);
        check("ferr_no_done", done_cnt - d0, 0);
        check("ferr_data_kept", rx_data, 8'h84);
        check("ferr_busy_end", busy, 1'b0);
        snap();
        send_frame(8'h81, 1'b1);
        idle(100);
        check("ferr_next_done", done_cnt - d0, 1);
        check("ferr_next_data", rx_data, 8'h81);

`ifdef UART_RX_PARITY_EN
        // Parity error: 0x83 has even parity bit 1; send 0 instead
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h83 >> i) & 8'h01) != 0);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(100);
        check("perr_cnt", perr_cnt - p0, 1);
        check("perr_no_done", done_cnt - d0, 0);
        check("perr_no_ferr", ferr_cnt - f0, 0);
        check("perr_data_kept", rx_data, 8'h81);
`endif

        // Mid-frame reset at bit 4 of 0x55
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h55 >> i) & 8'h01) != 0);
        rst = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_busy", busy, 1'b0);
        check("mrst_data", rx_data, 8'h00);
        idle(2000);
        check("mrst_no_done", done_cnt - d0, 0);
        check("mrst_no_ferr", ferr_cnt - f0, 0);
        check("mrst_no_perr", perr_cnt - p0, 0);
        snap();
        send_frame(8'h81, 1'b1);
        idle(100);
        check("mrst_next_done", done_cnt - d0, 1);
        check("mrst_next_data", rx_data, 8'h81);

        check("no_consecutive_done", consec, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the board command link: it oversamples the asynchronous serial input at 16× baud and deserialises 8N1 frames, LSB first. It sits directly upstream of the DC motor controller and drives that block's `rx_data` / `rx_done` inputs. Each good frame produces one byte and a single-cycle `rx_done` pulse. Malformed frames are flagged and never delivered.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in baud.
- `DIV` (derived, not overridable) = `CLK_FREQ / (16*BAUD_RATE)`, truncated. It must be ≥ 2; otherwise it is an elaboration error.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst` input, 1 bit: one clock; reset is synchronous and active-low.
- `rx` input, 1 bit: asynchronous serial line; idle level is high.
- `rx_data` output, 8 bits: last good byte, held until the next good frame.
- `rx_done` output, 1 bit: one-cycle pulse, coincident with `rx_data` update.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `parity_err` output, 1 bit: one-cycle pulse on parity mismatch; constant 0 without the macro.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer, reset to 1. Only the synchronized `rx_s` is used downstream.
- Tick generator: counts 0..DIV-1 and emits a one-cycle `tick` at DIV-1. It free-runs, restarting at 0 on reset and on IDLE→START.
- Tick counter `tcnt` (4 bits) counts ticks within a bit. Bit counter `bcnt` (3 bits) counts data bits.
- FSM states, with all transitions evaluated on `tick` except IDLE:
  - IDLE: on `rx_s`==0, go to START with `tcnt`=0.
  - START: at `tcnt`==7 (mid-bit), if `rx_s`==1 it is a glitch and the FSM returns to IDLE. Otherwise it clears `tcnt` and `bcnt` and goes to DATA.
  - DATA: at `tcnt`==15, shift `rx_s` into bit `bcnt` of the shift register (LSB first). At `bcnt`==7, go to PARITY if enabled, else STOP. `bcnt` wraps 7→0.
  - PARITY: at `tcnt`==15, sample the parity bit and go to STOP.
  - STOP: at `tcnt`==15, sample the stop bit.
    - Stop bit 1 with parity OK: `rx_data` ← shift register, pulse `rx_done`, go to IDLE.
    - Stop bit 0: pulse `frame_err` and go to BREAK. `rx_data` is unchanged and `rx_done` does not pulse.
    - Stop bit 1 with parity bad: pulse `parity_err` and go to IDLE. `rx_data` is unchanged and `rx_done` does not pulse.
  - BREAK: wait for `rx_s`==1 (no tick needed), then go to IDLE. This prevents a held-low line from re-triggering.
- If parity and frame errors occur together, only `frame_err` pulses.
- `rx_done` is never high for more than one cycle and never on consecutive cycles. This is compatible with the downstream 0→1 edge detector.

## Timing
- Reset values: `rx_data`=8'h00, `rx_done`=0, `frame_err`=0, `parity_err`=0, `busy`=0. FSM is in IDLE, counters are 0, and the shift register is 0.
- Reset asserted mid-frame aborts the frame within one cycle and drops the partial byte. After release, the next falling edge starts a fresh frame.
- Synchronizer latency is 2 clocks. Start detection happens 1 clock after `rx_s` falls.
- Sample points: the start bit is checked at 8·DIV clocks after detection. Each later bit is sampled 16·DIV clocks after the previous sample.
- `rx_done` / `rx_data` update 1 clock after the stop-bit sample, about 9.5 bit-times after the start edge (10.5 with parity).
- Back-to-back frames: the stop-bit sample returns the FSM to IDLE mid-stop-bit. The next start edge is accepted immediately, with no gap required.
- Baud tolerance: ±3% cumulative error is handled, given mid-bit sampling.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1. The PARITY state is compiled in. Even parity is checked (XOR of data bits plus parity bit must be 0). `parity_err` is live.
- Not defined: frame is 8N1. The PARITY state is absent, DATA goes straight to STOP, and `parity_err` is tied to 0.

## Test plan
Bench parameters for all scenarios: `CLK_FREQ`=1_600_000, `BAUD_RATE`=10_000, so `DIV`=10 and one bit = 160 clocks.

- Reset check: drive `rst`=0 for 5 clocks with `rx`=1, then release → all outputs 0 and `busy`=0.
- Good frame: send 0x81 → exactly one `rx_done` pulse, `rx_data`=8'h81, pulse about 1520 clocks after the start edge, no error pulses.
- Back-to-back frames: send 0x80, 0x83, 0x84 with no idle gap → three `rx_done` pulses with `rx_data` = 0x80, 0x83, 0x84 in order.
- Glitch rejection: 40-clock low glitch on idle `rx` → FSM returns to IDLE, no pulses on any output.
- Frame error: 0x82 sent with the stop bit forced low and the line held low for 500 clocks → `frame_err` pulses once, `rx_data` keeps its previous value, no `rx_done`. A following good 0x81 is received correctly.
- Parity error (macro defined): 0x83 sent with an odd parity bit → `parity_err` pulses once, no `rx_done`. Mid-frame reset test: assert `rst` at bit 4 → no pulses, and the next 0x81 is received correctly.
